count_bcd_decoder: RTL and testbench
====================================

Name: count_bcd_decoder

Overview:
Takes the binary count from the stopwatch counter and converts it into packed BCD digits for the display path. It uses a sequential double-dabble algorithm: one input bit is processed per clock. It sits between the binary counter and the 7-segment or display driver. Both sides use valid/ready handshakes, so the display side can apply backpressure.

Parameters:
BIN_W, 32, width of the binary input count.
DIGITS, 10, number of BCD output digits. The default satisfies 10^DIGITS > 2^BIN_W, so the default configuration cannot overflow.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  in_bin holds a value to convert.
in_ready  output  1  block can accept a new value.
in_bin  input  BIN_W  binary count to convert.
out_valid  output  1  out_bcd and out_overflow are valid.
out_ready  input  1  downstream consumes the result.
out_bcd  output  4*DIGITS  packed BCD; digit 0 (least significant) is at bits [3:0].
out_overflow  output  1  input value >= 10^DIGITS; out_bcd is then the low DIGITS digits only.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_overflow=0, internal shift and BCD registers 0, bit counter 0.
- The reset response is the same when rst asserts mid-conversion or while holding a result. The pending result is discarded and not presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, capture in_bin into the shift register, clear the BCD accumulator and overflow flag, set the bit counter to BIN_W-1, and go to SHIFT.
- SHIFT:
  - in_ready=0 and out_valid=0.
  - Each cycle, apply add-3 correction to every accumulator digit that is >= 5.
  - Then shift {accumulator, shift register} left by 1, taking the MSB of the shift register into accumulator bit 0.
  - If the bit shifted out of the top digit is 1, set overflow (sticky).
  - When the bit counter reaches 0, go to DONE after that shift. Otherwise decrement the counter.
- Latency and throughput:
  - Exactly BIN_W SHIFT cycles per conversion.
  - out_valid rises BIN_W+1 edges after the accepting edge.
  - Throughput is one conversion per BIN_W+2 cycles minimum.
- DONE:
  - out_valid=1, in_ready=0.
  - out_bcd and out_overflow are held stable until a clock edge with out_ready=1.
  - On that edge, go to IDLE. No new input is accepted on the same edge; in_ready reasserts in the following cycle.
  - out_bcd keeps its last value in IDLE. It is only meaningful while out_valid=1.
- in_bin is sampled only on the accepting edge. Changes to it during SHIFT or DONE have no effect.
- Arithmetic:
  - The add-3 correction is done in 4-bit unsigned arithmetic per digit.
  - Digits never exceed 9 after a full conversion.
  - Width rules: the bit counter is $clog2(BIN_W) bits wide. The accumulator is 4*DIGITS bits wide.
- Boundaries:
  - in_bin=0 yields all-zero digits.
  - in_bin=2^BIN_W-1 is a legal input.
  - out_ready may be held high permanently with no lost results.
  - in_valid held high continuously causes back-to-back conversions, separated by one IDLE cycle.

Decomposition:
- Shared package count_disp_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_DIGIT_W=4;
  - constant ADD3_THRESH=5.
- One sub-module, bcd_add3_digit: a combinational 4-bit input and 4-bit output, returning d+3 if d>=5, else d. It is instantiated DIGITS times with a generate loop.
- The FSM, counter and shift datapath stay in count_bcd_decoder.

Test Plan:
- Reset then in_bin=0 with in_valid pulse -> out_valid exactly 33 edges after accept; out_bcd=0x0000000000; out_overflow=0.
- in_bin=12345 (0x3039) -> out_bcd=0x0000012345, out_overflow=0; in_ready=0 for the whole SHIFT/DONE period.
- in_bin=0xFFFFFFFF -> out_bcd=0x4294967295, out_overflow=0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_bcd and out_valid stable all 20 cycles. Raise out_ready -> out_valid falls next edge, and in_ready=1 the cycle after.
- Reset mid-conversion: assert rst at SHIFT cycle 10 -> all outputs at reset values immediately (asynchronous); no out_valid. A fresh conversion of 59 then yields 0x0000000059.
- DIGITS=4, BIN_W=16: in_bin=10000 -> out_overflow=1, out_bcd=0x0000. in_bin=9999 -> out_overflow=0, out_bcd=0x9999.

Source files
------------

// File: rtl/count_disp_pkg.sv
// Shared types and constants for the stopwatch display path.
package count_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
    import count_disp_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    // 4-bit wraparound is harmless: inputs never exceed 9, so d+3 stays <= 12.
    always_comb begin
        q = d;
        if (d >= ADD3_THRESH) q = d + 4'd3;
    end

endmodule

// File: rtl/count_bcd_decoder.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with valid/ready handshakes on both the counter and display sides.
module count_bcd_decoder
    import count_disp_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_overflow
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   shreg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    // Per-digit add-3 correction applied to the whole accumulator each SHIFT cycle.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .d (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; DONE returns to IDLE without accepting,
    // so back-to-back conversions always see one IDLE cycle in between.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift datapath: load on accept, correct-then-shift while converting, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_bin;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= CNT_W'(BIN_W - 1);
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
                    shreg <= shreg << 1;
                    // A bit leaving the top digit means the value needs more digits.
                    ovf   <= ovf | acc_adj[ACC_W-1];
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_bcd      = acc;
    assign out_overflow = ovf;

endmodule

// File: tb/tb_count_bcd_decoder.sv
// Directed bench for count_bcd_decoder: default 32-bit/10-digit instance plus a
// 16-bit/4-digit instance for the overflow boundary.
module tb_count_bcd_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default configuration
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [31:0] a_in_bin;
    logic [39:0] a_bcd;

    // Small configuration
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [15:0] b_in_bin;
    logic [15:0] b_bcd;

    int tests = 0;
    int fails = 0;

    count_bcd_decoder #(.BIN_W(32), .DIGITS(10)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_bcd), .out_overflow(a_ovf)
    );

    count_bcd_decoder #(.BIN_W(16), .DIGITS(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_bcd), .out_overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a value for one accepting edge (caller is at a negedge with DUT idle).
    task automatic a_accept(input logic [31:0] v);
        a_in_valid = 1'b1;
        a_in_bin   = v;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    // Counts edges with the accepting edge as edge 1, until out_valid is seen.
    task automatic a_wait(output int edges, output bit rdy_seen);
        edges    = 1;
        rdy_seen = 1'b0;
        while (!a_out_valid && edges < 200) begin
            if (a_in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic a_consume(input string tag);
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(a_out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(a_in_ready), 64'd1);
    endtask

    task automatic b_run(input logic [15:0] v, input string tag,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        b_in_valid = 1'b1;
        b_in_bin   = v;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd17);
        chk({tag, "_bcd"}, 64'(b_bcd), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(b_ovf), 64'(exp_ovf));
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  rdy;
        bit  seen;
        logic [39:0] held;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_bin = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_bin = '0; b_out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_in_ready",  64'(a_in_ready), 64'd1);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_bcd",       64'(a_bcd), 64'd0);
        chk("rst_ovf",       64'(a_ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero input: latency and all-zero digits
        a_accept(32'd0);
        a_wait(edges, rdy);
        chk("zero_latency", 64'(edges), 64'd33);
        chk("zero_bcd", 64'(a_bcd), 64'h00_0000_0000);
        chk("zero_ovf", 64'(a_ovf), 64'd0);
        a_consume("zero");

        // 12345; in_ready must stay low through SHIFT and DONE
        a_accept(32'd12345);
        a_in_bin = 32'hDEAD_BEEF;   // ignored after the accepting edge
        a_wait(edges, rdy);
        chk("d12345_ready_low", 64'(rdy), 64'd0);
        chk("d12345_done_ready", 64'(a_in_ready), 64'd0);
        chk("d12345_bcd", 64'(a_bcd), 64'h00_0001_2345);
        chk("d12345_ovf", 64'(a_ovf), 64'd0);
        a_consume("d12345");

        // All-ones input, then 20 cycles of backpressure
        a_accept(32'hFFFF_FFFF);
        a_wait(edges, rdy);
        chk("max_bcd", 64'(a_bcd), 64'h42_9496_7295);
        chk("max_ovf", 64'(a_ovf), 64'd0);
        held = a_bcd;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!a_out_valid || a_bcd !== held || a_in_ready) seen = 1'b1;
        end
        chk("bp_stable", 64'(seen), 64'd0);
        chk("bp_bcd_end", 64'(a_bcd), 64'h42_9496_7295);
        a_consume("bp");

        // Back-to-back with in_valid and out_ready held high; in_bin changed mid-conversion
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_bin    = 32'd123;
        @(posedge clk);
        @(negedge clk);
        a_in_bin = 32'd456;
        a_wait(edges, rdy);
        chk("b2b_first_latency", 64'(edges), 64'd33);
        chk("b2b_first_bcd", 64'(a_bcd), 64'h00_0000_0123);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_ready", 64'(a_in_ready), 64'd1);
        chk("b2b_idle_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_second_accepted", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0;
        a_wait(edges, rdy);
        chk("b2b_second_bcd", 64'(a_bcd), 64'h00_0000_0456);
        @(posedge clk);
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("b2b_end_valid", 64'(a_out_valid), 64'd0);

        // Reset in the middle of a conversion
        a_accept(32'd12345);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_bcd", 64'(a_bcd), 64'd0);
        chk("midrst_ovf", 64'(a_ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        a_accept(32'd59);
        a_wait(edges, rdy);
        chk("after_rst_bcd", 64'(a_bcd), 64'h00_0000_0059);
        chk("after_rst_ovf", 64'(a_ovf), 64'd0);
        a_consume("after_rst");

        // Small configuration: overflow boundary
        b_run(16'd10000, "b10000", 16'h0000, 1'b1);
        b_run(16'd9999,  "b9999",  16'h9999, 1'b0);
        b_run(16'd65535, "b65535", 16'h5535, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
